// File: rtl/router_pkt_reg_p.sv
// router_pkt_reg_p
//   Packet register and checker between the router input FSM and the
//   per-port FIFOs. It latches the header, forwards header, payload and
//   checksum bytes on dout, and parks one byte in hold_q while the
//   selected FIFO is full. It accumulates an XOR or CRC-8 checksum and
//   compares it with the trailing packet byte. It also compares the
//   payload count with the header length field and counts bad packets
//   in a saturating counter.
//
//   Flow control: there is no valid/ready pair on this block. A byte
//   is accepted whenever the FSM is in ld_state with pkt_valid high. If
//   fifo_full is high in that cycle, the byte goes to hold_q instead of
//   dout, and it is replayed on dout in the following laf_state.
//
// Ports
//   clock, resetn      rising-edge clock, asynchronous active-low reset
//   pkt_valid          high for header/payload, low on the checksum byte
//   fifo_full          selected FIFO is full
//   detect_add, lfd_state, ld_state, laf_state, full_state
//                      one-hot FSM state indications
//   rst_int_reg        clears low_packet_valid
//   data_in            input byte
//   dout               byte to FIFO
//   parity_done        checksum byte captured
//   low_packet_valid   end of packet seen
//   err                checksum mismatch
//   len_err            payload count differs from the header length field
//   err_count          saturating count of packets with err or len_err
module router_pkt_reg_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3,
    parameter int CHK_MODE  = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic                 fifo_full,
    input  logic                 detect_add,
    input  logic                 lfd_state,
    input  logic                 ld_state,
    input  logic                 laf_state,
    input  logic                 full_state,
    input  logic                 rst_int_reg,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    dout,
    output logic                 parity_done,
    output logic                 low_packet_valid,
    output logic                 err,
    output logic                 len_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int                   LEN_W      = DATA_W - ADDR_W;
    localparam logic [DATA_W-1:0]    CRC_POLY   = DATA_W'(7);
    localparam logic [LEN_W-1:0]     LEN_MAX    = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = '1;
    localparam logic [ADDR_W:0]      PORT_LIMIT = (ADDR_W + 1)'(NUM_PORTS);

    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] pkt_chk_q;
    logic [LEN_W-1:0]  pay_cnt;
    logic              parity_done_d;

    logic hdr_ok;
    logic check_pulse;
    logic chk_bad;
    logic len_bad;

    // One checksum step: XOR the byte in, then (CRC mode) clock the
    // result through DATA_W MSB-first shifts of the CRC register.
    function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] c,
                                               input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] x;
        x = c ^ b;
        if (CHK_MODE == 1) begin
            for (int i = 0; i < DATA_W; i++) begin
                x = x[DATA_W-1] ? ((x << 1) ^ CRC_POLY) : (x << 1);
            end
        end
        return x;
    endfunction

    assign hdr_ok      = {1'b0, data_in[ADDR_W-1:0]} < PORT_LIMIT;
    // The checks run in the cycle after parity_done rises. By then
    // pkt_chk_q holds the received checksum and chk has stopped moving.
    assign check_pulse = parity_done & ~parity_done_d;
    assign chk_bad     = chk != pkt_chk_q;
    assign len_bad     = pay_cnt != hdr_q[DATA_W-1:ADDR_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout             <= '0;
            parity_done      <= 1'b0;
            parity_done_d    <= 1'b0;
            low_packet_valid <= 1'b0;
            err              <= 1'b0;
            len_err          <= 1'b0;
            err_count        <= '0;
            hdr_q            <= '0;
            hold_q           <= '0;
            chk              <= '0;
            pkt_chk_q        <= '0;
            pay_cnt          <= '0;
        end else begin
            parity_done_d <= parity_done;

            if (check_pulse) begin
                err     <= chk_bad;
                len_err <= len_bad;
                if ((chk_bad || len_bad) && err_count != ERR_MAX) begin
                    err_count <= err_count + ERR_CNT_W'(1);
                end
            end

            // The state inputs are one-hot. The if/else chain gives the
            // priority used when several of them are high.
            if (detect_add) begin
                if (pkt_valid && hdr_ok) begin
                    hdr_q       <= data_in;
                    chk         <= '0;
                    pay_cnt     <= '0;
                    parity_done <= 1'b0;
                    err         <= 1'b0;
                    len_err     <= 1'b0;
                end
            end else if (lfd_state) begin
                dout <= hdr_q;
                chk  <= fold('0, hdr_q);
            end else if (ld_state) begin
                if (pkt_valid) begin
                    chk <= fold(chk, data_in);
                    if (pay_cnt != LEN_MAX) begin
                        pay_cnt <= pay_cnt + LEN_W'(1);
                    end
                    if (fifo_full) begin
                        hold_q <= data_in;
                    end else begin
                        dout <= data_in;
                    end
                end else begin
                    low_packet_valid <= 1'b1;
                    if (fifo_full) begin
                        hold_q <= data_in;
                    end else begin
                        pkt_chk_q   <= data_in;
                        dout        <= data_in;
                        parity_done <= 1'b1;
                    end
                end
            end else if (laf_state) begin
                // Replay the parked byte. Its checksum contribution was
                // already taken when it was first accepted.
                dout <= hold_q;
                if (low_packet_valid && !parity_done) begin
                    pkt_chk_q   <= hold_q;
                    parity_done <= 1'b1;
                end
            end else if (full_state) begin
                // Waiting on the FIFO: every register holds.
            end

            // The clear takes priority over a set in the same cycle.
            if (rst_int_reg) begin
                low_packet_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_reg_p.sv
module tb_router_pkt_reg_p;

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_DET  = 5'b10000;
  localparam logic [4:0] S_LFD  = 5'b01000;
  localparam logic [4:0] S_LD   = 5'b00100;
  localparam logic [4:0] S_LAF  = 5'b00010;
  localparam logic [4:0] S_FULL = 5'b00001;

  // clock / reset
  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  logic       pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
  logic       laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic       fifo_we = 1'b0;

  logic [7:0] dout0, dout1;
  logic       parity_done0, parity_done1, low_packet_valid0, low_packet_valid1;
  logic       err0, err1, len_err0, len_err1;
  logic [7:0] err_count0, err_count1;

  router_pkt_reg_p #(.CHK_MODE(0)) dut0 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout0), .parity_done(parity_done0),
    .low_packet_valid(low_packet_valid0), .err(err0), .len_err(len_err0),
    .err_count(err_count0)
  );

  router_pkt_reg_p #(.CHK_MODE(1)) dut1 (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .data_in(data_in), .dout(dout1), .parity_done(parity_done1),
    .low_packet_valid(low_packet_valid1), .err(err1), .len_err(len_err1),
    .err_count(err_count1)
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [9:0] res0_q[$];
  logic [9:0] res1_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] pay[0:127];
  int         ec0, ec1;
  logic [7:0] last_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  // driver tasks
  task automatic step();
    @(negedge clock);
  endtask

  task automatic drive(input logic [4:0] st, input logic pv, input logic ff,
                       input logic [7:0] d, input logic we, input logic ri);
    {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
    pkt_valid   = pv;
    fifo_full   = ff;
    data_in     = d;
    fifo_we     = we;
    rst_int_reg = ri;
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    last_b = b;
  endtask

  // Reference checksum over the byte stream header, pay[0..n-1]:
  // mode 0 is the XOR of all bytes, mode 1 is a bit-serial CRC-8
  // (poly 0x07, MSB first, init 0) run over the whole stream.
  function automatic logic [7:0] model_chk(input int mode, input logic [7:0] hdr, input int n);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k <= n; k++) begin
      b = (k == 0) ? hdr : pay[k-1];
      if (mode == 0) begin
        c = c ^ b;
      end else begin
        for (int j = 7; j >= 0; j--) begin
          fb = c[7] ^ b[j];
          c  = {c[6:0], 1'b0};
          if (fb) c = c ^ 8'h07;
        end
      end
    end
    return c;
  endfunction

  // One byte accepted in ld_state. If fm is set, the FIFO is full and
  // the byte is replayed through full_state and laf_state.
  task automatic send_byte(input logic pv, input logic fm, input logic [7:0] b);
    step();
    if (fm) begin
      drive(S_LD, pv, 1'b1, b, 1'b0, 1'b0);
      step();
      check("dout_hold0", dout0, last_b);
      check("dout_hold1", dout1, last_b);
      drive(S_FULL, pv, 1'b1, 8'($urandom), 1'b0, 1'b0);
      step();
      drive(S_LAF, pv, 1'b0, 8'($urandom), 1'b1, 1'b0);
    end else begin
      drive(S_LD, pv, 1'b0, b, 1'b1, 1'b0);
    end
    push_byte(b);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] cb,
                          input logic [127:0] fm);
    logic [7:0] c0, c1;
    int         cnt;
    logic       le, e0, e1;
    c0  = model_chk(0, hdr, n);
    c1  = model_chk(1, hdr, n);
    cnt = (n > 63) ? 63 : n;
    le  = (cnt != int'(hdr[7:2]));
    e0  = (cb != c0);
    e1  = (cb != c1);
    if ((e0 || le) && ec0 < 255) ec0++;
    if ((e1 || le) && ec1 < 255) ec1++;
    res0_q.push_back({e0, le, 8'(ec0)});
    res1_q.push_back({e1, le, 8'(ec1)});

    step();
    drive(S_DET, 1'b1, 1'b0, hdr, 1'b0, 1'b0);
    step();
    check("clr_parity_done0", parity_done0, 1'b0);
    check("clr_parity_done1", parity_done1, 1'b0);
    check("clr_err0", err0, 1'b0);
    check("clr_err1", err1, 1'b0);
    check("clr_len_err0", len_err0, 1'b0);
    check("clr_len_err1", len_err1, 1'b0);
    drive(S_LFD, 1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
    push_byte(hdr);
    for (int i = 0; i < n; i++) send_byte(1'b1, fm[i], pay[i]);
    send_byte(1'b0, fm[n], cb);
    step();
    check("lpv_set0", low_packet_valid0, 1'b1);
    check("lpv_set1", low_packet_valid1, 1'b1);
    check("parity_done0", parity_done0, 1'b1);
    check("parity_done1", parity_done1, 1'b1);
    drive(S_IDLE, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
    step();
    check("lpv_clr0", low_packet_valid0, 1'b0);
    check("lpv_clr1", low_packet_valid1, 1'b0);
    drive(S_IDLE, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout0"}, dout0, 8'h00);
    check({tag, "_dout1"}, dout1, 8'h00);
    check({tag, "_pd0"}, parity_done0, 1'b0);
    check({tag, "_pd1"}, parity_done1, 1'b0);
    check({tag, "_lpv0"}, low_packet_valid0, 1'b0);
    check({tag, "_lpv1"}, low_packet_valid1, 1'b0);
    check({tag, "_err0"}, err0, 1'b0);
    check({tag, "_err1"}, err1, 1'b0);
    check({tag, "_len_err0"}, len_err0, 1'b0);
    check({tag, "_len_err1"}, len_err1, 1'b0);
    check({tag, "_err_count0"}, err_count0, 8'h00);
    check({tag, "_err_count1"}, err_count1, 8'h00);
  endtask

  // monitor: bytes written to the FIFO
  logic       we_s;
  logic [7:0] e_b;
  always begin
    @(posedge clock);
    we_s = fifo_we;
    #1;
    if (we_s) begin
      if (exp_q.size() == 0) begin
        fail_msg("dout");
      end else begin
        e_b = exp_q.pop_front();
        check("dout0", dout0, e_b);
        check("dout1", dout1, e_b);
      end
    end
  end

  // monitor: packet verdicts, compared one cycle after parity_done rises
  logic       pend0 = 1'b0, pend1 = 1'b0, pd0_prev = 1'b0, pd1_prev = 1'b0;
  logic [9:0] r0, r1;
  always begin
    @(posedge clock);
    #1;
    if (pend0) begin
      pend0 = 1'b0;
      if (res0_q.size() == 0) fail_msg("result0");
      else begin
        r0 = res0_q.pop_front();
        check("err0", err0, r0[9]);
        check("len_err0", len_err0, r0[8]);
        check("err_count0", err_count0, r0[7:0]);
      end
    end
    if (pend1) begin
      pend1 = 1'b0;
      if (res1_q.size() == 0) fail_msg("result1");
      else begin
        r1 = res1_q.pop_front();
        check("err1", err1, r1[9]);
        check("len_err1", len_err1, r1[8]);
        check("err_count1", err_count1, r1[7:0]);
      end
    end
    if (parity_done0 && !pd0_prev) pend0 = 1'b1;
    if (parity_done1 && !pd1_prev) pend1 = 1'b1;
    pd0_prev = parity_done0;
    pd1_prev = parity_done1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0]   c, h, cb;
  int           len, n, sel;
  logic [127:0] fm;

  initial begin
    resetn = 1'b1;
    drive(S_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    ec0 = 0;
    ec1 = 0;
    last_b = 8'h00;
    #2 resetn = 1'b0;
    #1 check_zero("por");
    step();
    step();
    resetn = 1'b1;

    // good XOR packet, then the same packet with an inverted checksum
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    c = model_chk(0, 8'h0D, 3);
    send_pkt(8'h0D, 3, c, '0);
    send_pkt(8'h0D, 3, c ^ 8'hFF, '0);

    // header for port 3 is ignored: flags stay, lfd replays the old header
    step();
    drive(S_DET, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b0);
    step();
    check("ign_pd0", parity_done0, 1'b1);
    check("ign_err0", err0, 1'b1);
    check("ign_err_count0", err_count0, 8'(ec0));
    drive(S_LFD, 1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
    push_byte(8'h0D);
    step();
    drive(S_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // FIFO full on the 2nd payload byte, then full on the checksum byte
    send_pkt(8'h0D, 3, c, 128'b0010);
    send_pkt(8'h0D, 3, c, 128'b1000);

    // CRC packets: correct byte for mode 1, then with bit 0 flipped
    pay[0] = 8'h01;
    c = model_chk(1, 8'h05, 1);
    send_pkt(8'h05, 1, c, '0);
    send_pkt(8'h05, 1, c ^ 8'h01, '0);

    // length 3 with only 2 payload bytes
    pay[0] = 8'h11; pay[1] = 8'h22;
    send_pkt(8'h0D, 2, model_chk(0, 8'h0D, 2), '0);

    // payload counter saturates at the length-field maximum (63)
    for (int i = 0; i < 66; i++) pay[i] = 8'($urandom);
    send_pkt(8'hFE, 66, model_chk(0, 8'hFE, 66), '0);
    send_pkt(8'hFE, 63, model_chk(1, 8'hFE, 63), '0);
    send_pkt(8'hFE, 62, model_chk(0, 8'hFE, 62), '0);

    // randomized packets
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 6);
      h   = {6'(len), 2'($urandom_range(0, 2))};
      n   = len + int'($urandom_range(0, 2)) - 1;
      if (n < 0) n = 0;
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      fm = '0;
      for (int i = 0; i <= n; i++) fm[i] = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 2);
      cb  = (sel == 0) ? model_chk(0, h, n) : (sel == 1) ? model_chk(1, h, n) : 8'($urandom);
      send_pkt(h, n, cb, fm);
    end

    // drive the error counter into saturation
    repeat (260) send_pkt(8'h00, 0, 8'hFF, '0);

    // asynchronous reset in the middle of a payload
    step();
    drive(S_DET, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0);
    step();
    drive(S_LFD, 1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
    push_byte(8'h0D);
    step();
    drive(S_LD, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0);
    push_byte(8'h11);
    @(posedge clock);
    #3;
    resetn = 1'b0;
    drive(S_IDLE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1 check_zero("async");
    ec0 = 0;
    ec1 = 0;
    step();
    step();
    resetn = 1'b1;

    // a fresh packet after reset
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_pkt(8'h0A, 2, model_chk(0, 8'h0A, 2), '0);

    repeat (4) step();
    check("exp_q_empty", exp_q.size(), 0);
    check("res0_q_empty", res0_q.size(), 0);
    check("res1_q_empty", res1_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
